instr_fetch_unit: RTL and testbench

Issue-side partner of the NN processor control unit. Owns the program counter, reads 32-bit instruction words from instruction memory, and presents each word to the decoder. Advances the PC by the decoder's returned step. A step of 0 (illegal opcode) is a fault and halts issue. Sits between the instruction ROM/RAM and the control unit inside the processor core.

---
 rtl/instr_fetch_unit_pkg.sv | 20 ++
 rtl/instr_fetch_unit_sat_counter.sv | 34 +++
 rtl/instr_fetch_unit.sv | 129 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit and its neighbours:
// the fetch state encoding, default widths and the opcodes used by benches.
package instr_fetch_unit_pkg;

    localparam int IFU_PC_W    = 8;
    localparam int IFU_INSTR_W = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_ISSUE = 3'd3,
        S_HALT  = 3'd4
    } ifu_state_t;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LD  = 8'h01;
    localparam logic [7:0] OP_OP2 = 8'h02;

endpackage

// File: rtl/instr_fetch_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Count events; clear wins over increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= sat_inc(r_count);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads one word per instruction from
// a 1-cycle-latency memory, presents it to the decoder and advances by the
// decoder's step. A zero step is an illegal opcode and parks the unit in HALT.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int PC_W    = IFU_PC_W,
    parameter int INSTR_W = IFU_INSTR_W,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [PC_W-1:0]    base_pc,
    input  logic               abort,
    input  logic               stall,
    output logic               imem_rd_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic [PC_W-1:0]    dec_next_pc,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               halted,
    output logic               fault,
    output logic               wrapped,
    output logic [CNT_W-1:0]   retired
);

    ifu_state_t         r_state;
    ifu_state_t         w_state_next;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic               r_fault;
    logic               r_wrapped;

    logic [PC_W:0]      w_pc_sum;
    logic               w_start_ok;
    logic               w_issue_go;
    logic               w_retire;
    logic               w_fault_hit;
    logic               w_capture;

    // Extra bit on the sum carries the wrap indication.
    assign w_pc_sum    = {1'b0, r_pc} + {1'b0, dec_next_pc};

    // abort always masks start, including in IDLE.
    assign w_start_ok  = start && !abort && ((r_state == S_IDLE) || (r_state == S_HALT));
    assign w_issue_go  = (r_state == S_ISSUE) && !abort && !stall;
    assign w_retire    = w_issue_go && (dec_next_pc != '0);
    assign w_fault_hit = w_issue_go && (dec_next_pc == '0);
    assign w_capture   = (r_state == S_WAIT) && !abort;

    // Next-state selection; abort overrides everything else.
    always_comb begin
        w_state_next = r_state;
        if (abort) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        w_state_next = S_FETCH;
                    end
                end
                S_FETCH: w_state_next = S_WAIT;
                S_WAIT:  w_state_next = S_ISSUE;
                S_ISSUE: begin
                    if (!stall) begin
                        w_state_next = (dec_next_pc == '0) ? S_HALT : S_FETCH;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // State, PC, captured instruction and sticky flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_instr   <= '0;
            r_fault   <= 1'b0;
            r_wrapped <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_start_ok) begin
                r_pc      <= base_pc;
                r_fault   <= 1'b0;
                r_wrapped <= 1'b0;
            end
            if (w_retire) begin
                r_pc <= w_pc_sum[PC_W-1:0];
                if (w_pc_sum[PC_W]) begin
                    r_wrapped <= 1'b1;
                end
            end
            if (w_fault_hit) begin
                r_fault <= 1'b1;
            end
            if (w_capture) begin
                r_instr <= imem_rdata;
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_retired (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_start_ok),
        .inc   (w_retire),
        .count (retired)
    );

    assign imem_rd_en  = (r_state == S_FETCH);
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = (r_state == S_ISSUE);
    assign pc          = r_pc;
    assign busy        = (r_state == S_FETCH) || (r_state == S_WAIT) || (r_state == S_ISSUE);
    assign halted      = (r_state == S_HALT);
    assign fault       = r_fault;
    assign wrapped     = r_wrapped;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a 1-cycle memory, a stand-in decoder that
// returns steps from the opcode byte, directed scenarios and randomized
// programs checked against an instruction-level trace model.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 32;
    localparam int CNT_W   = 4;
    localparam int RET_MAX = 15;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [PC_W-1:0]    base_pc = '0;
    logic               abort = 1'b0;
    logic               stall = 1'b0;
    logic               imem_rd_en;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic [PC_W-1:0]    dec_next_pc;
    logic [PC_W-1:0]    pc;
    logic               busy;
    logic               halted;
    logic               fault;
    logic               wrapped;
    logic [CNT_W-1:0]   retired;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [256];
    logic [31:0] mem_q = '0;
    logic        junk_en = 1'b0;
    logic [57:0] outs;

    instr_fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_pc(base_pc),
        .abort(abort), .stall(stall), .imem_rd_en(imem_rd_en),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instr(instr),
        .instr_valid(instr_valid), .dec_next_pc(dec_next_pc), .pc(pc),
        .busy(busy), .halted(halted), .fault(fault), .wrapped(wrapped),
        .retired(retired)
    );

    always #5 clk = ~clk;

    // Instruction memory with one cycle of read latency.
    always @(posedge clk) if (imem_rd_en) mem_q <= mem[imem_addr];
    assign imem_rdata = junk_en ? 32'hDEADBEEF : mem_q;

    function automatic int step_of(input logic [31:0] w);
        case (w[31:24])
            OP_NOP:  return 1;
            OP_LD:   return 2;
            OP_OP2:  return 3;
            default: return 0;
        endcase
    endfunction

    // Decoder stand-in.
    assign dec_next_pc = 8'(step_of(instr));
    assign outs = {imem_rd_en, imem_addr, instr, instr_valid, pc, busy, halted, fault, wrapped, retired};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [31:0] w);
        for (int i = 0; i < 256; i++) mem[i] = w;
    endtask

    // Takes one edge (start or issue), then waits for the next issue.
    task automatic wait_valid(output int n, output int rd_cnt, output logic [7:0] rd_addr);
        tick();
        start = 1'b0;
        n = 1;
        rd_cnt = 0;
        rd_addr = '0;
        if (imem_rd_en) begin rd_cnt++; rd_addr = imem_addr; end
        while (!instr_valid && n < 12) begin
            tick();
            n++;
            if (imem_rd_en) begin rd_cnt++; rd_addr = imem_addr; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; junk_en = 1'b1;
        tick();
        rst_n = 1'b1; junk_en = 1'b0;
        vectors++; if (outs !== '0) begin miscompares++; $display("FAIL reset_outputs: got %h expected 0", outs); end
        tick(); tick();
        vectors++; if (busy !== 1'b0 || imem_rd_en !== 1'b0) begin miscompares++; $display("FAIL reset_idle: busy=%b rd_en=%b expected 0 0", busy, imem_rd_en); end
    endtask

    task automatic test_nop_fault();
        int n, rc; logic [7:0] ra;
        fill(32'hFF000000);
        mem[8'h10] = 32'h00000000;
        start = 1'b1; base_pc = 8'h10;
        wait_valid(n, rc, ra);
        vectors++; if (n != 3 || pc !== 8'h10) begin miscompares++; $display("FAIL nop_first_issue: cycles=%0d pc=%h expected 3 10", n, pc); end
        vectors++; if (rc != 1 || ra !== 8'h10) begin miscompares++; $display("FAIL nop_first_read: reads=%0d addr=%h expected 1 10", rc, ra); end
        wait_valid(n, rc, ra);
        vectors++; if (n != 3 || pc !== 8'h11 || instr !== 32'hFF000000) begin miscompares++; $display("FAIL nop_second_issue: cycles=%0d pc=%h instr=%h expected 3 11 ff000000", n, pc, instr); end
        tick();
        vectors++; if ({halted, fault, busy, pc, retired} !== {1'b1, 1'b1, 1'b0, 8'h11, 4'd1}) begin miscompares++; $display("FAIL nop_halt: halted=%b fault=%b busy=%b pc=%h retired=%0d expected 1 1 0 11 1", halted, fault, busy, pc, retired); end
        tick(); tick();
        vectors++; if (imem_rd_en !== 1'b0 || halted !== 1'b1 || pc !== 8'h11) begin miscompares++; $display("FAIL halt_hold: rd_en=%b halted=%b pc=%h expected 0 1 11", imem_rd_en, halted, pc); end
    endtask

    task automatic test_step_program();
        int n, rc; logic [7:0] ra;
        logic [7:0] exp_pcs [3];
        exp_pcs[0] = 8'h00; exp_pcs[1] = 8'h02; exp_pcs[2] = 8'h05;
        fill(32'h00000000);
        mem[8'h00] = 32'h01ABCDEF; mem[8'h02] = 32'h02123456; mem[8'h05] = 32'h7F000000;
        start = 1'b1; base_pc = 8'h00;
        for (int k = 0; k < 3; k++) begin
            wait_valid(n, rc, ra);
            vectors++; if (n != 3 || pc !== exp_pcs[k] || instr !== mem[exp_pcs[k]]) begin miscompares++; $display("FAIL step_issue%0d: cycles=%0d pc=%h instr=%h expected 3 %h %h", k, n, pc, instr, exp_pcs[k], mem[exp_pcs[k]]); end
            if (k == 0) begin
                vectors++; if (fault !== 1'b0 || retired !== 4'd0) begin miscompares++; $display("FAIL step_restart_clear: fault=%b retired=%0d expected 0 0", fault, retired); end
            end
        end
        tick();
        vectors++; if (retired !== 4'd2 || fault !== 1'b1 || halted !== 1'b1) begin miscompares++; $display("FAIL step_end: retired=%0d fault=%b halted=%b expected 2 1 1", retired, fault, halted); end
    endtask

    task automatic test_wrap();
        int n, rc; logic [7:0] ra;
        fill(32'hFF000000);
        mem[8'hFE] = 32'h02000000; mem[8'h01] = 32'h00000000;
        start = 1'b1; base_pc = 8'hFE;
        wait_valid(n, rc, ra);
        vectors++; if (pc !== 8'hFE || wrapped !== 1'b0) begin miscompares++; $display("FAIL wrap_first: pc=%h wrapped=%b expected fe 0", pc, wrapped); end
        wait_valid(n, rc, ra);
        vectors++; if (n != 3 || pc !== 8'h01 || wrapped !== 1'b1 || ra !== 8'h01) begin miscompares++; $display("FAIL wrap_next: cycles=%0d pc=%h wrapped=%b addr=%h expected 3 01 1 01", n, pc, wrapped, ra); end
        wait_valid(n, rc, ra);
        vectors++; if (pc !== 8'h02 || wrapped !== 1'b1 || retired !== 4'd2) begin miscompares++; $display("FAIL wrap_continue: pc=%h wrapped=%b retired=%0d expected 02 1 2", pc, wrapped, retired); end
        tick();
        vectors++; if (halted !== 1'b1 || wrapped !== 1'b1) begin miscompares++; $display("FAIL wrap_sticky: halted=%b wrapped=%b expected 1 1", halted, wrapped); end
    endtask

    task automatic test_stall();
        int n, rc; logic [7:0] ra; logic [31:0] ins;
        fill(32'hFF000000);
        mem[8'h30] = 32'h00C0FFEE; mem[8'h31] = 32'h00000001;
        start = 1'b1; base_pc = 8'h30;
        wait_valid(n, rc, ra);
        ins = instr;
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++; if ({instr_valid, pc, instr, retired} !== {1'b1, 8'h30, ins, 4'd0}) begin miscompares++; $display("FAIL stall_hold%0d: valid=%b pc=%h instr=%h retired=%0d expected 1 30 %h 0", i, instr_valid, pc, instr, retired, ins); end
        end
        stall = 1'b0;
        tick();
        vectors++; if ({retired, instr_valid, imem_rd_en, imem_addr} !== {4'd1, 1'b0, 1'b1, 8'h31}) begin miscompares++; $display("FAIL stall_release: retired=%0d valid=%b rd_en=%b addr=%h expected 1 0 1 31", retired, instr_valid, imem_rd_en, imem_addr); end
        abort = 1'b1; tick(); abort = 1'b0;
        vectors++; if (busy !== 1'b0 || pc !== 8'h31 || retired !== 4'd1) begin miscompares++; $display("FAIL abort_fetch: busy=%b pc=%h retired=%0d expected 0 31 1", busy, pc, retired); end
    endtask

    task automatic test_abort_wait();
        int n, rc; logic [7:0] ra;
        fill(32'hFF000000);
        mem[8'hFF] = 32'h00000000;
        start = 1'b1; base_pc = 8'hFF;
        wait_valid(n, rc, ra);
        tick(); tick();
        vectors++; if (busy !== 1'b1 || instr_valid !== 1'b0 || imem_rd_en !== 1'b0) begin miscompares++; $display("FAIL pre_abort_wait: busy=%b valid=%b rd_en=%b expected 1 0 0", busy, instr_valid, imem_rd_en); end
        abort = 1'b1; tick(); abort = 1'b0;
        vectors++; if ({busy, instr_valid, imem_rd_en, pc, wrapped, retired} !== {3'b000, 8'h00, 1'b1, 4'd1}) begin miscompares++; $display("FAIL abort_wait: busy=%b valid=%b rd_en=%b pc=%h wrapped=%b retired=%0d expected 0 0 0 00 1 1", busy, instr_valid, imem_rd_en, pc, wrapped, retired); end
        tick();
        vectors++; if (busy !== 1'b0 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL abort_stays_idle: busy=%b valid=%b expected 0 0", busy, instr_valid); end
        start = 1'b1; abort = 1'b1; base_pc = 8'h40;
        tick();
        start = 1'b0; abort = 1'b0;
        tick();
        vectors++; if (busy !== 1'b0 || wrapped !== 1'b1 || pc !== 8'h00) begin miscompares++; $display("FAIL start_abort_idle: busy=%b wrapped=%b pc=%h expected 0 1 00", busy, wrapped, pc); end
        mem[8'h20] = 32'h00000000; mem[8'h21] = 32'h00000000; mem[8'h22] = 32'h00000000;
        start = 1'b1; base_pc = 8'h20;
        wait_valid(n, rc, ra);
        vectors++; if ({n == 3, pc, wrapped, fault, retired} !== {1'b1, 8'h20, 1'b0, 1'b0, 4'd0}) begin miscompares++; $display("FAIL restart_after_abort: cycles=%0d pc=%h wrapped=%b fault=%b retired=%0d expected 3 20 0 0 0", n, pc, wrapped, fault, retired); end
        start = 1'b1; base_pc = 8'h55;
        tick();
        start = 1'b0;
        tick(); tick();
        vectors++; if (instr_valid !== 1'b1 || pc !== 8'h21 || retired !== 4'd1) begin miscompares++; $display("FAIL start_while_busy: valid=%b pc=%h retired=%0d expected 1 21 1", instr_valid, pc, retired); end
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    task automatic test_reset_mid_issue();
        int n, rc; logic [7:0] ra;
        fill(32'h00000000);
        start = 1'b1; base_pc = 8'h20;
        wait_valid(n, rc, ra);
        vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL rst_pre_issue: valid=%b expected 1", instr_valid); end
        junk_en = 1'b1; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++; if (outs !== '0) begin miscompares++; $display("FAIL rst_mid_issue: got %h expected 0", outs); end
        tick(); tick();
        vectors++; if (busy !== 1'b0 || instr !== 32'h0 || pc !== 8'h00) begin miscompares++; $display("FAIL rst_needs_start: busy=%b instr=%h pc=%h expected 0 0 00", busy, instr, pc); end
        junk_en = 1'b0;
        start = 1'b1; base_pc = 8'h21;
        wait_valid(n, rc, ra);
        vectors++; if (n != 3 || pc !== 8'h21 || instr !== mem[8'h21]) begin miscompares++; $display("FAIL rst_resume: cycles=%0d pc=%h instr=%h expected 3 21 %h", n, pc, instr, mem[8'h21]); end
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    task automatic test_saturation();
        int n, rc; logic [7:0] ra; int exp;
        fill(32'h00000000);
        start = 1'b1; base_pc = 8'h00;
        wait_valid(n, rc, ra);
        for (int k = 0; k < 20; k++) begin
            exp = (k > RET_MAX) ? RET_MAX : k;
            vectors++; if (retired !== 4'(exp) || pc !== 8'(k)) begin miscompares++; $display("FAIL sat_issue%0d: retired=%0d pc=%h expected %0d %h", k, retired, pc, exp, 8'(k)); end
            if (k < 19) wait_valid(n, rc, ra);
        end
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    task automatic test_random();
        int n, rc, s, exp_ret; logic [7:0] ra; logic [7:0] p; logic w; bit ends_fault; int r;
        logic [7:0] pcs [$]; bit wrs [$];
        for (int trial = 0; trial < 8; trial++) begin
            for (int i = 0; i < 256; i++) begin
                r = $urandom_range(0, 19);
                mem[i] = {(r < 6) ? OP_NOP : (r < 12) ? OP_LD : (r < 18) ? OP_OP2 : 8'($urandom_range(3, 255)), 24'($urandom)};
            end
            base_pc = 8'($urandom);
            pcs.delete(); wrs.delete();
            p = base_pc; w = 1'b0; ends_fault = 1'b0;
            for (int k = 0; k < 12; k++) begin
                pcs.push_back(p); wrs.push_back(w);
                s = step_of(mem[p]);
                if (s == 0) begin ends_fault = 1'b1; break; end
                if (int'(p) + s > 255) w = 1'b1;
                p = 8'(int'(p) + s);
            end
            start = 1'b1;
            for (int k = 0; k < pcs.size(); k++) begin
                wait_valid(n, rc, ra);
                exp_ret = (k > RET_MAX) ? RET_MAX : k;
                vectors++; if (n != 3 || rc != 1 || ra !== pcs[k]) begin miscompares++; $display("FAIL rnd%0d_fetch%0d: cycles=%0d reads=%0d addr=%h expected 3 1 %h", trial, k, n, rc, ra, pcs[k]); end
                vectors++; if ({pc, instr, retired, wrapped, fault} !== {pcs[k], mem[pcs[k]], 4'(exp_ret), wrs[k], 1'b0}) begin miscompares++; $display("FAIL rnd%0d_issue%0d: pc=%h instr=%h retired=%0d wrapped=%b fault=%b expected %h %h %0d %b 0", trial, k, pc, instr, retired, wrapped, fault, pcs[k], mem[pcs[k]], exp_ret, wrs[k]); end
                if ($urandom_range(0, 99) < 30) begin
                    stall = 1'b1;
                    repeat ($urandom_range(1, 3)) tick();
                    stall = 1'b0;
                    vectors++; if (instr_valid !== 1'b1 || pc !== pcs[k] || retired !== 4'(exp_ret)) begin miscompares++; $display("FAIL rnd%0d_stall%0d: valid=%b pc=%h retired=%0d expected 1 %h %0d", trial, k, instr_valid, pc, retired, pcs[k], exp_ret); end
                end
            end
            if (ends_fault) begin
                tick();
                vectors++; if ({halted, fault, pc, retired} !== {1'b1, 1'b1, pcs[pcs.size()-1], 4'(pcs.size()-1)}) begin miscompares++; $display("FAIL rnd%0d_fault: halted=%b fault=%b pc=%h retired=%0d expected 1 1 %h %0d", trial, halted, fault, pc, retired, pcs[pcs.size()-1], pcs.size()-1); end
            end else begin
                abort = 1'b1; stall = 1'b1; tick(); abort = 1'b0; stall = 1'b0;
                vectors++; if ({busy, instr_valid, pc, retired} !== {2'b00, pcs[pcs.size()-1], 4'(pcs.size()-1)}) begin miscompares++; $display("FAIL rnd%0d_abort: busy=%b valid=%b pc=%h retired=%0d expected 0 0 %h %0d", trial, busy, instr_valid, pc, retired, pcs[pcs.size()-1], pcs.size()-1); end
            end
        end
    endtask

    initial begin
        fill(32'h00000000);
        test_reset();
        test_nop_fault();
        test_step_program();
        test_wrap();
        test_stall();
        test_abort_wait();
        test_reset_mid_issue();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "time limit");
    end

endmodule
